// File: rtl/cam_bien_bang_chuyen_if.sv
// Signal bundle between the conveyor front-end and its surroundings:
// raw sensor/button inputs, counter feedback, and the pulse/motor/jam outputs.
interface cam_bien_bang_chuyen_if;
  logic sensor_in;
  logic start_btn;
  logic box_full;
  logic product_pulse;
  logic motor_en;
  logic jam;

  modport master (
    output sensor_in, start_btn, box_full,
    input  product_pulse, motor_en, jam
  );

  modport slave (
    input  sensor_in, start_btn, box_full,
    output product_pulse, motor_en, jam
  );
endinterface

// File: rtl/cam_bien_bang_chuyen.sv
// Conveyor front-end: synchronises and debounces the product sensor, emits one
// count pulse per product, and runs the motor enable with full/jam stop logic.
module cam_bien_bang_chuyen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int JAM_CYCLES      = 50000000
) (
  input logic              clk,
  input logic              rst,
  cam_bien_bang_chuyen_if.slave bus
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > JAM_CYCLES) ? DEBOUNCE_CYCLES : JAM_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} deb_state_t;
  typedef enum logic {STOP, RUN} mot_state_t;

  logic sen_p0, sen_p1;
  logic start_p0, start_p1, start_p2;
  logic s_sen, start_rise;

  deb_state_t       deb_state, deb_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             rise_accept, jam_hit;

  mot_state_t mot_state, mot_next;
  logic       jam_q, jam_next;
  logic       pulse_q, pulse_next;

  // Stage p0/p1: two-flop synchronisers; start_p2 holds the previous s_start for edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sen_p0   <= 1'b0;
      sen_p1   <= 1'b0;
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
    end else begin
      sen_p0   <= bus.sensor_in;
      sen_p1   <= sen_p0;
      start_p0 <= bus.start_btn;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
    end
  end

  assign s_sen      = sen_p1;
  assign start_rise = start_p1 & ~start_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_state <= S_LOW;
      cnt       <= '0;
      mot_state <= STOP;
      jam_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      deb_state <= deb_next;
      cnt       <= cnt_next;
      mot_state <= mot_next;
      jam_q     <= jam_next;
      pulse_q   <= pulse_next;
    end
  end

  // The same counter times debounce in S_RISE/S_FALL and the jam window in S_HIGH
  always_comb begin
    deb_next    = deb_state;
    cnt_next    = cnt;
    rise_accept = 1'b0;
    jam_hit     = 1'b0;
    case (deb_state)
      S_LOW: begin
        if (s_sen) begin
          deb_next = S_RISE;
          cnt_next = '0;
        end
      end
      S_RISE: begin
        if (!s_sen) begin
          deb_next = S_LOW;
        end else if (cnt == DEB_LAST) begin
          deb_next    = S_HIGH;
          cnt_next    = '0;
          rise_accept = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        jam_hit = (cnt == JAM_LAST);
        if (!s_sen) begin
          deb_next = S_FALL;
          cnt_next = '0;
        end else if (cnt != JAM_LAST) begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_FALL: begin
        if (s_sen) begin
          deb_next = S_HIGH;
          cnt_next = '0;
        end else if (cnt == DEB_LAST) begin
          deb_next = S_LOW;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        deb_next = S_LOW;
        cnt_next = '0;
      end
    endcase
  end

  // A jammed line may only restart once the sensor has genuinely cleared (S_LOW)
  always_comb begin
    mot_next   = mot_state;
    jam_next   = jam_q;
    pulse_next = rise_accept && (mot_state == RUN);
    case (mot_state)
      RUN: begin
        if (bus.box_full || jam_hit) begin
          mot_next = STOP;
          jam_next = jam_q | jam_hit;
        end
      end
      STOP: begin
        if (start_rise && !bus.box_full && (!jam_q || deb_state == S_LOW)) begin
          mot_next = RUN;
          jam_next = 1'b0;
        end
      end
      default: mot_next = STOP;
    endcase
  end

  assign bus.product_pulse = pulse_q;
  assign bus.motor_en      = (mot_state == RUN);
  assign bus.jam           = jam_q;

endmodule

// File: tb/tb_cam_bien_bang_chuyen.sv
// Scoreboard bench: a run-length reference model predicts pulse/motor/jam per edge,
// a negedge monitor compares DUT outputs against the queued predictions.
module tb_cam_bien_bang_chuyen;
  localparam int D = 4;
  localparam int J = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_bien_bang_chuyen_if bus();

  cam_bien_bang_chuyen #(.DEBOUNCE_CYCLES(D), .JAM_CYCLES(J)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e, mon_a;

  // Reference model: synchroniser delay lines plus accepted level and run length
  bit m_sd1, m_sd2, m_td1, m_td2, m_td3;
  bit m_acc, m_run, m_jam;
  int m_runlen, m_hold;

  task automatic model_edge();
    bit s, sr, jam_hit, in_low, n_pulse, n_run, n_jam;
    if (!rst) begin
      {m_sd1, m_sd2, m_td1, m_td2, m_td3} = '0;
      {m_acc, m_run, m_jam} = '0;
      m_runlen = 0;
      m_hold   = 0;
      exp_q.push_back(3'b000);
      return;
    end
    s       = m_sd2;
    sr      = m_td2 && !m_td3;
    jam_hit = m_acc && (m_runlen == 0) && (m_hold == J - 1);
    in_low  = !m_acc && (m_runlen == 0);
    n_pulse = !m_acc && s && (m_runlen == D) && m_run;
    n_run   = m_run;
    n_jam   = m_jam;
    if (m_run) begin
      if (bus.box_full || jam_hit) begin
        n_run = 1'b0;
        n_jam = m_jam || jam_hit;
      end
    end else if (sr && !bus.box_full && (!m_jam || in_low)) begin
      n_run = 1'b1;
      n_jam = 1'b0;
    end
    if (s != m_acc) begin
      m_runlen++;
      if (m_runlen == D + 1) begin
        m_acc    = s;
        m_runlen = 0;
        m_hold   = 0;
      end
    end else begin
      if (m_acc) m_hold = (m_runlen > 0) ? 0 : ((m_hold < J - 1) ? m_hold + 1 : m_hold);
      m_runlen = 0;
    end
    m_sd2 = m_sd1;
    m_sd1 = bus.sensor_in;
    m_td3 = m_td2;
    m_td2 = m_td1;
    m_td1 = bus.start_btn;
    m_run = n_run;
    m_jam = n_jam;
    exp_q.push_back({n_pulse, n_run, n_jam});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic press(input int n);
    bus.start_btn = 1'b1;
    step(n);
    bus.start_btn = 1'b0;
    step(3);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check("async_reset_outputs", int'({bus.product_pulse, bus.motor_en, bus.jam}), 0);
    step(2);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {bus.product_pulse, bus.motor_en, bus.jam};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs t=%0t pulse/motor/jam got %b expected %b", $time, mon_a, mon_e);
        end
        if (bus.product_pulse === 1'b1) pulse_seen++;
      end
    end
  end

  initial begin
    int p0;
    int n;
    rst           = 1'b0;
    bus.sensor_in = 1'b0;
    bus.start_btn = 1'b0;
    bus.box_full  = 1'b0;
    step(2);
    @(negedge clk);
    #1 rst = 1'b1;
    step(2);

    // Start press then one clean product
    bus.start_btn = 1'b1;
    step(4);
    check("motor_after_press", int'(bus.motor_en), 1);
    bus.start_btn = 1'b0;
    p0 = pulse_seen;
    bus.sensor_in = 1'b1;
    step(10);
    bus.sensor_in = 1'b0;
    step(10);
    check("one_product_pulse", pulse_seen - p0, 1);

    // Short glitch is ignored
    p0 = pulse_seen;
    bus.sensor_in = 1'b1;
    step(3);
    bus.sensor_in = 1'b0;
    step(8);
    check("glitch_no_pulse", pulse_seen - p0, 0);

    // Ten clean products, then one with a short dropout
    p0 = pulse_seen;
    for (int i = 0; i < 10; i++) begin
      bus.sensor_in = 1'b1;
      step(8);
      bus.sensor_in = 1'b0;
      step(8);
    end
    check("ten_products", pulse_seen - p0, 10);
    p0 = pulse_seen;
    bus.sensor_in = 1'b1;
    step(8);
    bus.sensor_in = 1'b0;
    step(2);
    bus.sensor_in = 1'b1;
    step(6);
    bus.sensor_in = 1'b0;
    step(10);
    check("dropout_single_pulse", pulse_seen - p0, 1);

    // Pallet full stops the motor and blocks restart
    bus.box_full = 1'b1;
    step(1);
    check("box_full_stops", int'(bus.motor_en), 0);
    press(3);
    check("press_ignored_full", int'(bus.motor_en), 0);
    bus.box_full = 1'b0;
    step(2);
    press(3);
    check("restart_after_full", int'(bus.motor_en), 1);

    // Jam: sensor held high
    bus.sensor_in = 1'b1;
    step(60);
    check("jam_set", int'(bus.jam), 1);
    check("jam_motor_off", int'(bus.motor_en), 0);
    press(3);
    check("press_ignored_jam", int'(bus.motor_en), 0);
    bus.sensor_in = 1'b0;
    step(10);
    press(3);
    check("jam_cleared", int'(bus.jam), 0);
    check("jam_restart", int'(bus.motor_en), 1);

    // Reset in S_RISE with cnt=2 while running
    bus.sensor_in = 1'b1;
    step(5);
    reset_pulse();
    step(3);
    press(3);
    step(10);
    bus.sensor_in = 1'b0;
    step(10);

    // Randomised traffic
    press(3);
    for (int i = 0; i < 250; i++) begin
      bus.sensor_in = 1'($urandom_range(0, 1));
      bus.start_btn = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.box_full = ~bus.box_full;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 10);
      step(n);
      if ($urandom_range(0, 60) == 0) reset_pulse();
    end

    bus.sensor_in = 1'b0;
    bus.start_btn = 1'b0;
    step(5);
    @(negedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
